// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-writable word memory with one-cycle registered read data,
// sticky out-of-range error capture and read/write access counters.
module data_sram_resp #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0]       mem [Depth];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              is_wr;
  logic [31:0]       merged;

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  assign idx      = data_sram_addr[ADDR_W+1:2];
  assign in_range = (data_sram_addr[31:ADDR_W+2] == '0);
  assign is_wr    = |data_sram_wen;

  // Old word with written lanes replaced; equals the stored word on a read.
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  // Memory has no reset; accesses during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && data_sram_en && is_wr && in_range) begin
      mem[idx] <= merged;
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (data_sram_en) begin
      rdata_d = in_range ? merged : 32'h0;
      if (is_wr) wr_cnt_d = wr_cnt_q + 32'd1;
      else       rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = 32'h0;
    end
    // A new error beats a simultaneous clear; otherwise only the first one is captured.
    if (data_sram_en && !in_range) begin
      err_d = 1'b1;
      if (!err_q || err_clr) err_addr_d = data_sram_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
      rd_cnt_q   <= 32'h0;
      wr_cnt_q   <= 32'h0;
    end else begin
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign err             = err_q;
  assign err_addr        = err_addr_q;
  assign rd_cnt          = rd_cnt_q;
  assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed vector table, hand sequences and randomized traffic
// checked against a word-array reference model.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        clr;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .err             (err),
    .err_addr        (err_addr),
    .err_clr         (clr),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  // Reference model state
  logic [31:0] m_mem [1024];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_ea;
  logic [31:0] m_rd;
  logic [31:0] m_wr;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] ea;
    logic [31:0] rd;
    logic [31:0] wr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d, logic c,
                              logic [31:0] r, logic er, logic [31:0] ea, logic [31:0] rc,
                              logic [31:0] wc);
    vec_t v;
    v.rst = 1'b0; v.en = e; v.wen = w; v.addr = a; v.wdata = d; v.clr = c;
    v.rdata = r; v.err = er; v.ea = ea; v.rd = rc; v.wr = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; return 1 ns after the rising edge.
  task automatic drive(input logic r, input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic c);
    reset = r; en = e; wen = w; addr = a; wdata = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic r, input logic e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d, input logic c);
    logic        oor;
    logic [31:0] word;
    if (r) begin
      m_rdata = 0; m_err = 0; m_ea = 0; m_rd = 0; m_wr = 0;
      return;
    end
    oor = (a >> 12) != 0;
    if (e) begin
      if (w != 0) m_wr = m_wr + 1;
      else        m_rd = m_rd + 1;
      if (oor) begin
        m_rdata = 0;
      end else begin
        word = m_mem[a[11:2]];
        for (int i = 0; i < 4; i++) if (w[i]) word[8*i +: 8] = d[8*i +: 8];
        if (w != 0) m_mem[a[11:2]] = word;
        m_rdata = word;
      end
    end
    if (e && oor) begin
      if (!m_err || c) m_ea = a;
      m_err = 1;
    end else if (c) begin
      m_err = 0;
      m_ea  = 0;
    end
  endtask

  task automatic step(input string name, input logic r, input logic e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d, input logic c);
    drive(r, e, w, a, d, c);
    model_step(r, e, w, a, d, c);
    chk({name, ".rdata"},    rdata,           m_rdata);
    chk({name, ".err"},      {31'b0, err},    {31'b0, m_err});
    chk({name, ".err_addr"}, err_addr,        m_ea);
    chk({name, ".rd_cnt"},   rd_cnt,          m_rd);
    chk({name, ".wr_cnt"},   wr_cnt,          m_wr);
  endtask

  initial begin
    logic [31:0] bb_data[4];
    logic [31:0] a;
    logic [3:0]  w;

    vecs[0]  = mk(1, 4'hF, 32'h10,       32'h12345678, 0, 32'h12345678, 0, 32'h0,    0, 1);
    vecs[1]  = mk(1, 4'h0, 32'h10,       32'h0,        0, 32'h12345678, 0, 32'h0,    1, 1);
    vecs[2]  = mk(1, 4'h2, 32'h10,       32'h0000AB00, 0, 32'h1234AB78, 0, 32'h0,    1, 2);
    vecs[3]  = mk(1, 4'h0, 32'h10,       32'h0,        0, 32'h1234AB78, 0, 32'h0,    2, 2);
    vecs[4]  = mk(1, 4'h8, 32'h10,       32'hCD000000, 0, 32'hCD34AB78, 0, 32'h0,    2, 3);
    vecs[5]  = mk(1, 4'h0, 32'h10,       32'h0,        0, 32'hCD34AB78, 0, 32'h0,    3, 3);
    vecs[6]  = mk(1, 4'hF, 32'h4,        32'h11111111, 0, 32'h11111111, 0, 32'h0,    3, 4);
    vecs[7]  = mk(1, 4'hF, 32'h1004,     32'h22222222, 0, 32'h0,        1, 32'h1004, 3, 5);
    vecs[8]  = mk(1, 4'h0, 32'h4,        32'h0,        0, 32'h11111111, 1, 32'h1004, 4, 5);
    vecs[9]  = mk(1, 4'h0, 32'h80000000, 32'h0,        0, 32'h0,        1, 32'h1004, 5, 5);
    vecs[10] = mk(0, 4'h0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0,    5, 5);
    vecs[11] = mk(1, 4'h0, 32'h2000,     32'h0,        1, 32'h0,        1, 32'h2000, 6, 5);
    vecs[12] = mk(0, 4'h0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h2000, 6, 5);
    vecs[13] = mk(1, 4'h0, 32'h10,       32'h0,        0, 32'hCD34AB78, 1, 32'h2000, 7, 5);
    vecs[14] = mk(0, 4'hF, 32'h10,       32'hFFFFFFFF, 0, 32'hCD34AB78, 1, 32'h2000, 7, 5);
    vecs[15] = mk(1, 4'h0, 32'h10,       32'h0,        0, 32'hCD34AB78, 1, 32'h2000, 8, 5);

    reset = 1; en = 0; wen = 0; addr = 0; wdata = 0; clr = 0;

    // Reset with a write presented: outputs zero, nothing written, nothing counted
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0);
      chk("reset.rdata",    rdata,        32'h0);
      chk("reset.err",      {31'b0, err}, 32'h0);
      chk("reset.err_addr", err_addr,     32'h0);
      chk("reset.rd_cnt",   rd_cnt,       32'h0);
      chk("reset.wr_cnt",   wr_cnt,       32'h0);
    end
    drive(0, 1, 4'h0, 32'h0, 32'h0, 0);
    n_checks++;
    if (rdata === 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL reset.nowrite: got %h, expected anything but deadbeef", rdata);
    end
    chk("reset.after.wr_cnt", wr_cnt, 32'h0);
    chk("reset.after.rd_cnt", rd_cnt, 32'h1);

    // Directed vector table
    drive(1, 0, 4'h0, 32'h0, 32'h0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
      chk($sformatf("vec%0d.rdata", i),    rdata,        vecs[i].rdata);
      chk($sformatf("vec%0d.err", i),      {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("vec%0d.err_addr", i), err_addr,     vecs[i].ea);
      chk($sformatf("vec%0d.rd_cnt", i),   rd_cnt,       vecs[i].rd);
      chk($sformatf("vec%0d.wr_cnt", i),   wr_cnt,       vecs[i].wr);
    end

    // Back-to-back alternating write/read stream
    step("b2b.rst", 1, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      bb_data[k] = $urandom;
      step($sformatf("b2b.wr%0d", k), 0, 1, 4'hF, 32'(4 * k), bb_data[k], 0);
      step($sformatf("b2b.rd%0d", k), 0, 1, 4'h0, 32'(4 * k), 32'h0, 0);
      chk($sformatf("b2b.data%0d", k), rdata, bb_data[k]);
    end
    chk("b2b.rd_total", rd_cnt, 32'd4);
    chk("b2b.wr_total", wr_cnt, 32'd4);

    // Randomized traffic over 16 words plus out-of-range addresses
    step("rnd.rst", 1, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 16; k++) step("rnd.init", 0, 1, 4'hF, 32'(4 * k), $urandom, 0);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom;
        if ((a >> 12) == 0) a[31] = 1'b1;
      end else begin
        a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      end
      w = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      step("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), w, a, $urandom,
           ($urandom_range(0, 7) == 0));
    end

    // Counter wrap
    step("wrap.rst", 1, 0, 4'h0, 32'h0, 32'h0, 0);
    step("wrap.wr", 0, 1, 4'hF, 32'h0, 32'hA5A5A5A5, 0);
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt_q;
    #1;
    m_rd = 32'hFFFF_FFFF;
    chk("wrap.preset", rd_cnt, 32'hFFFF_FFFF);
    step("wrap.rd", 0, 1, 4'h0, 32'h0, 32'h0, 0);
    chk("wrap.rd_cnt", rd_cnt, 32'h0);
    chk("wrap.wr_cnt", wr_cnt, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
